// File: rtl/sfr_bank_if.sv
// Register bus between a host and the SFR bank: address, write/read strobes and read data.
interface sfr_bank_if;
   logic [7:0] addr;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       rd_valid;
   logic [7:0] rd_data;

   modport master (
      output addr,
      output wr_data,
      output wr_valid,
      output rd_valid,
      input  rd_data
   );

   modport slave (
      input  addr,
      input  wr_data,
      input  wr_valid,
      input  rd_valid,
      output rd_data
   );
endinterface

// File: rtl/sfr_bank.sv
// Special-function register bank: prescaled timer with overflow irq, PWM settings,
// encoder bias correction and a small serial TX FIFO.
module sfr_bank #(
   parameter int unsigned PWM_CH     = 3,
   parameter int unsigned TMR_W      = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TICK_DIV   = 50
) (
   input  logic                clk,
   input  logic                nrst,
   sfr_bank_if.slave           bus,
   output logic [7:0]          pwm_period,
   output logic [7:0]          pwm_dt,
   output logic [PWM_CH*8-1:0] pwm_duty,
   input  logic [7:0]          enc_cnt,
   output logic [7:0]          enc_divr,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                irq
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [7:0]       tmr_divr_q, pwm_dt_q, pwm_period_q, enc_divr_q, bias_q;
   logic [1:0]       ctrl_q;
   logic [7:0]       duty_q [PWM_CH];
   logic [7:0]       tick_cnt_q, presc_q;
   logic [TMR_W-1:0] timer_q;
   logic [23:0]      shadow_q;
   logic             tov_q, fov_q;
   logic [7:0]       fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;

   logic        wr, tick, timer_clr, status_wr, sout_wr;
   logic        fifo_full, fifo_empty, push, pop, tov_set, fov_set;
   logic [31:0] timer_ext;

   assign wr         = bus.wr_valid;
   assign tick       = (tick_cnt_q == 8'(TICK_DIV - 1));
   assign timer_clr  = wr && (bus.addr[7:2] == 6'b000001);
   assign status_wr  = wr && (bus.addr == 8'h03);
   assign sout_wr    = wr && (bus.addr == 8'h0C);
   assign fifo_full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = sout_wr && !fifo_full;
   assign pop        = !fifo_empty && tx_ready;
   // A clearing write to the timer also suppresses the overflow it would otherwise cause.
   assign tov_set    = tick && ctrl_q[0] && (presc_q == 8'd0) && (&timer_q) && !timer_clr;
   assign fov_set    = sout_wr && fifo_full;
   assign timer_ext  = 32'(timer_q);

   // Plain configuration registers and encoder bias.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         tmr_divr_q   <= '0;
         ctrl_q       <= '0;
         pwm_dt_q     <= '0;
         pwm_period_q <= '0;
         enc_divr_q   <= '0;
         bias_q       <= '0;
         for (int unsigned i = 0; i < PWM_CH; i++) duty_q[i] <= '0;
      end else if (wr) begin
         case (bus.addr)
            8'h01:   tmr_divr_q   <= bus.wr_data;
            8'h02:   ctrl_q       <= bus.wr_data[1:0];
            8'h08:   pwm_dt_q     <= bus.wr_data;
            8'h09:   pwm_period_q <= bus.wr_data;
            8'h0A:   enc_divr_q   <= bus.wr_data;
            8'h0B:   bias_q       <= enc_cnt - bus.wr_data;
            default: ;
         endcase
         for (int unsigned i = 0; i < PWM_CH; i++) begin
            if (bus.addr == 8'(16 + i)) duty_q[i] <= bus.wr_data;
         end
      end
   end

   // Free-running tick divider, prescaler and timer.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         tick_cnt_q <= '0;
         presc_q    <= '0;
         timer_q    <= '0;
      end else begin
         tick_cnt_q <= tick ? 8'd0 : tick_cnt_q + 8'd1;
         if (timer_clr) begin
            presc_q <= '0;
            timer_q <= '0;
         end else if (tick && ctrl_q[0]) begin
            if (presc_q == 8'd0) begin
               presc_q <= tmr_divr_q;
               timer_q <= timer_q + TMR_W'(1);
            end else begin
               presc_q <= presc_q - 8'd1;
            end
         end
      end
   end

   // Reading byte0 snapshots the upper bytes so a multi-byte read is coherent.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         shadow_q <= '0;
      end else if (bus.rd_valid && (bus.addr == 8'h04)) begin
         shadow_q <= timer_ext[31:8];
      end
   end

   // Sticky status flags; a same-cycle set beats the write-1-to-clear.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         tov_q <= 1'b0;
         fov_q <= 1'b0;
      end else begin
         tov_q <= (tov_q & ~(status_wr & bus.wr_data[0])) | tov_set;
         fov_q <= (fov_q & ~(status_wr & bus.wr_data[3])) | fov_set;
      end
   end

   // TX FIFO storage and pointers.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= bus.wr_data;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
            2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
            default: ;
         endcase
      end
   end

   // Combinational read mux; unmapped addresses read zero.
   always_comb begin
      bus.rd_data = '0;
      case (bus.addr)
         8'h01:   bus.rd_data = tmr_divr_q;
         8'h02:   bus.rd_data = {6'b0, ctrl_q};
         8'h03:   bus.rd_data = {4'b0, fov_q, fifo_empty, fifo_full, tov_q};
         8'h04:   bus.rd_data = timer_ext[7:0];
         8'h05:   bus.rd_data = shadow_q[7:0];
         8'h06:   bus.rd_data = shadow_q[15:8];
         8'h07:   bus.rd_data = shadow_q[23:16];
         8'h08:   bus.rd_data = pwm_dt_q;
         8'h09:   bus.rd_data = pwm_period_q;
         8'h0A:   bus.rd_data = enc_divr_q;
         8'h0B:   bus.rd_data = enc_cnt - bias_q;
         default: ;
      endcase
      for (int unsigned i = 0; i < PWM_CH; i++) begin
         if (bus.addr == 8'(16 + i)) bus.rd_data = duty_q[i];
      end
   end

   // Output wiring.
   always_comb begin
      pwm_duty = '0;
      for (int unsigned i = 0; i < PWM_CH; i++) pwm_duty[8*i +: 8] = duty_q[i];
   end

   assign pwm_period = pwm_period_q;
   assign pwm_dt     = pwm_dt_q;
   assign enc_divr   = enc_divr_q;
   assign tx_data    = fifo_q[rd_ptr_q];
   assign tx_valid   = !fifo_empty;
   assign irq        = tov_q & ctrl_q[1];

endmodule

// File: tb/tb_sfr_bank.sv
// Bench for sfr_bank: random traffic against a queue/arithmetic model plus directed scenarios.
// TICK_DIV=1 lets a 16-bit timer wrap within the cycle budget.
module tb_sfr_bank;
   localparam int unsigned PWM_CH     = 3;
   localparam int unsigned TMR_W      = 16;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned TICK_DIV   = 1;
   localparam int unsigned TMAX       = (32'd1 << TMR_W) - 1;

   logic                clk = 1'b0;
   logic                nrst;
   logic [7:0]          pwm_period, pwm_dt, enc_cnt, enc_divr, tx_data;
   logic [PWM_CH*8-1:0] pwm_duty;
   logic                tx_valid, tx_ready, irq;

   sfr_bank_if bus_if ();

   sfr_bank #(
      .PWM_CH    (PWM_CH),
      .TMR_W     (TMR_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .TICK_DIV  (TICK_DIV)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .bus       (bus_if),
      .pwm_period(pwm_period),
      .pwm_dt    (pwm_dt),
      .pwm_duty  (pwm_duty),
      .enc_cnt   (enc_cnt),
      .enc_divr  (enc_divr),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid = 1'b0;
   int unsigned m_tick, m_presc, m_timer, m_shadow;
   int unsigned m_divr, m_ctrl, m_dt, m_period, m_encdivr, m_bias;
   int unsigned m_duty [8];
   bit          m_tov, m_fov;
   byte unsigned m_q [$];

   task automatic model_edge();
      bit          tick, wr, tov_set;
      int unsigned a, d, occ;
      if (!nrst) begin
         m_tick = 0; m_presc = 0; m_timer = 0; m_shadow = 0;
         m_divr = 0; m_ctrl = 0; m_dt = 0; m_period = 0; m_encdivr = 0; m_bias = 0;
         for (int i = 0; i < 8; i++) m_duty[i] = 0;
         m_tov = 0; m_fov = 0;
         m_q.delete();
         m_valid = 1'b1;
         return;
      end
      tick    = (m_tick == TICK_DIV - 1);
      wr      = bus_if.wr_valid;
      a       = bus_if.addr;
      d       = bus_if.wr_data;
      occ     = m_q.size();
      tov_set = 1'b0;
      if (bus_if.rd_valid && a == 4) m_shadow = m_timer >> 8;
      if (wr && a >= 4 && a <= 7) begin
         m_timer = 0;
         m_presc = 0;
      end else if (tick && m_ctrl[0]) begin
         if (m_presc == 0) begin
            m_presc = m_divr;
            if (m_timer == TMAX) tov_set = 1'b1;
            m_timer = (m_timer + 1) & TMAX;
         end else begin
            m_presc = m_presc - 1;
         end
      end
      m_tick = (m_tick + 1) % TICK_DIV;
      if (wr && a == 3) begin
         if (d[0]) m_tov = 1'b0;
         if (d[3]) m_fov = 1'b0;
      end
      if (tov_set) m_tov = 1'b1;
      if (occ > 0 && tx_ready) void'(m_q.pop_front());
      if (wr && a == 12) begin
         if (occ == FIFO_DEPTH) m_fov = 1'b1;
         else m_q.push_back(byte'(d));
      end
      if (wr) begin
         if (a == 1) m_divr = d;
         if (a == 2) m_ctrl = d & 3;
         if (a == 8) m_dt = d;
         if (a == 9) m_period = d;
         if (a == 10) m_encdivr = d;
         if (a == 11) m_bias = (enc_cnt - d) & 255;
         if (a >= 16 && a < 16 + PWM_CH) m_duty[a-16] = d;
      end
   endtask

   function automatic logic [7:0] exp_rd(input int unsigned a, input int unsigned enc);
      int unsigned v = 0;
      int unsigned occ = m_q.size();
      if (a == 1) v = m_divr;
      else if (a == 2) v = m_ctrl;
      else if (a == 3)
         v = (m_fov ? 8 : 0) | (occ == 0 ? 4 : 0) | (occ == FIFO_DEPTH ? 2 : 0) | (m_tov ? 1 : 0);
      else if (a == 4) v = m_timer & 255;
      else if (a >= 5 && a <= 7) v = (a - 4 < TMR_W / 8) ? (m_shadow >> (8 * (a - 5))) & 255 : 0;
      else if (a == 8) v = m_dt;
      else if (a == 9) v = m_period;
      else if (a == 10) v = m_encdivr;
      else if (a == 11) v = (enc - m_bias) & 255;
      else if (a >= 16 && a < 16 + PWM_CH) v = m_duty[a-16];
      return v[7:0];
   endfunction

   always @(posedge clk) model_edge();

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [PWM_CH*8-1:0] e;
      if (m_valid) begin
         chk("rd_data", bus_if.rd_data, exp_rd(bus_if.addr, enc_cnt));
         chk("tx_valid", tx_valid, m_q.size() != 0);
         if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
         chk("irq", irq, m_tov && m_ctrl[1]);
         chk("pwm_period", pwm_period, m_period);
         chk("pwm_dt", pwm_dt, m_dt);
         chk("enc_divr", enc_divr, m_encdivr);
         for (int i = 0; i < PWM_CH; i++) e[8*i +: 8] = m_duty[i][7:0];
         chk("pwm_duty", pwm_duty, e);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus_if.addr     = a;
      bus_if.wr_data  = d;
      bus_if.wr_valid = 1'b1;
      step(1);
      bus_if.wr_valid = 1'b0;
   endtask

   task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
      bus_if.addr = a;
      @(negedge clk);
      chk(name, bus_if.rd_data, exp);
      step(1);
   endtask

   task automatic wait_timer(input int unsigned target, input string name);
      int guard = 0;
      bus_if.addr = 8'h04;
      while (m_timer != target && guard < 70000) begin
         step(1);
         guard++;
      end
      chk(name, guard < 70000, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      nrst            = 1'b0;
      bus_if.addr     = '0;
      bus_if.wr_data  = '0;
      bus_if.wr_valid = 1'b0;
      bus_if.rd_valid = 1'b0;
      tx_ready        = 1'b0;
      enc_cnt         = '0;
      step(2);
      nrst = 1'b1;

      rd_chk(8'h03, 8'h04, "reset_status");
      chk("reset_tx_valid", tx_valid, 0);
      chk("reset_irq", irq, 0);

      for (int c = 0; c < 1500; c++) begin
         int unsigned r;
         nrst            = ($urandom_range(0, 299) != 0);
         bus_if.wr_valid = ($urandom_range(0, 9) < 3);
         bus_if.rd_valid = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 9);
         if (r < 8) bus_if.addr = 8'($urandom_range(0, 12));
         else if (r == 8) bus_if.addr = 8'(16 + $urandom_range(0, 7));
         else bus_if.addr = 8'($urandom_range(0, 255));
         bus_if.wr_data = 8'($urandom);
         tx_ready       = 1'($urandom_range(0, 1));
         enc_cnt        = 8'($urandom);
         step(1);
      end
      nrst            = 1'b1;
      bus_if.wr_valid = 1'b0;
      bus_if.rd_valid = 1'b0;

      // FIFO fill past full, then drain in order.
      wr(8'h02, 8'h00);
      tx_ready = 1'b1;
      step(6);
      wr(8'h03, 8'h09);
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) wr(8'h0C, 8'(8'h41 + i));
      rd_chk(8'h03, 8'h0A, "fifo_full_fov");
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("drain_valid", tx_valid, 1);
         chk("drain_data", tx_data, 8'h41 + i);
         step(1);
      end
      @(negedge clk);
      chk("drain_empty_valid", tx_valid, 0);
      step(1);
      rd_chk(8'h03, 8'h0C, "drain_status");

      // Encoder bias.
      enc_cnt = 8'h30;
      wr(8'h0B, 8'h05);
      rd_chk(8'h0B, 8'h05, "enc_30");
      enc_cnt = 8'h32;
      rd_chk(8'h0B, 8'h07, "enc_32");
      enc_cnt = 8'h2A;
      rd_chk(8'h0B, 8'hFF, "enc_2a");

      // Unmapped duty slot and NOP.
      wr(8'h13, 8'h77);
      rd_chk(8'h13, 8'h00, "duty3_unmapped");
      rd_chk(8'h00, 8'h00, "nop_read");

      // Prescaler 3 with one tick per clock: one increment every 4 clocks.
      wr(8'h01, 8'h03);
      wr(8'h02, 8'h01);
      wr(8'h04, 8'h00);
      step(40);
      rd_chk(8'h04, 8'h0A, "tmr_k40");
      rd_chk(8'h04, 8'h0B, "tmr_k41");
      step(2);
      rd_chk(8'h04, 8'h0B, "tmr_k44");
      rd_chk(8'h04, 8'h0C, "tmr_k45");

      // Shadow coherence at 0x12FF.
      wr(8'h01, 8'h00);
      wr(8'h05, 8'h00);
      wait_timer(32'h12FF, "wait_12ff");
      bus_if.rd_valid = 1'b1;
      @(negedge clk);
      chk("byte0_live", bus_if.rd_data, 8'hFF);
      step(1);
      bus_if.rd_valid = 1'b0;
      rd_chk(8'h05, 8'h12, "byte1_shadow");

      // Wrap with a simultaneous W1C: TOV must survive.
      wait_timer(TMAX, "wait_ffff");
      wr(8'h03, 8'h09);
      rd_chk(8'h03, 8'h05, "tov_set_wins");
      chk("irq_ctrl01", irq, 0);
      wr(8'h02, 8'h03);
      chk("irq_ctrl03", irq, 1);
      wr(8'h03, 8'h01);
      chk("irq_after_w1c", irq, 0);
      rd_chk(8'h03, 8'h04, "tov_cleared");

      // Reset mid-operation.
      wr(8'h02, 8'h01);
      wr(8'h10, 8'h55);
      wr(8'h12, 8'hAA);
      tx_ready = 1'b0;
      wr(8'h0C, 8'h01);
      wr(8'h0C, 8'h02);
      wr(8'h0C, 8'h03);
      @(negedge clk);
      chk("pre_reset_valid", tx_valid, 1);
      step(1);
      nrst = 1'b0;
      step(1);
      nrst = 1'b1;
      bus_if.addr = 8'h04;
      @(negedge clk);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_timer", bus_if.rd_data, 8'h00);
      chk("rst_duty", pwm_duty, 0);
      chk("rst_irq", irq, 0);
      step(1);
      rd_chk(8'h03, 8'h04, "rst_status");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
